hilo_unit: RTL and testbench

Multiplier result stage of the ALU datapath: captures the 64-bit product from the 32x32 multiplier and commits it to the architectural HI/LO register pair after a programmable multi-cycle latency. Serves MFHI/MFLO reads and MTHI/MTLO writes. Asserts a pipeline stall while a multiply is in flight and a HI/LO access is attempted. Sits directly downstream of the multiplier; its read port feeds the register-file write-back mux.

---
 rtl/hilo_unit_pkg.sv | 14 +
 rtl/hilo_unit.sv | 101 ++++++++++
 tb/tb_hilo_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared types and constants for the HI/LO multiply result stage.
package hilo_unit_pkg;

   localparam int HILO_W      = 32;
   localparam int PROD_W      = 64;
   localparam int LATENCY_MAX = 16;
   localparam int CNT_W       = $clog2(LATENCY_MAX);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/hilo_unit.sv
// HI/LO register pair: commits the multiplier product after LATENCY cycles and
// serves move-from/move-to accesses, stalling them while a multiply is in flight.
module hilo_unit
   import hilo_unit_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [PROD_W-1:0]   prod,
   input  logic                mfhi,
   input  logic                mflo,
   input  logic                mthi,
   input  logic                mtlo,
   input  logic [HILO_W-1:0]   wr_data,
   output logic [HILO_W-1:0]   rd_data,
   output logic                busy,
   output logic                stall,
   output logic [HILO_W-1:0]   hi,
   output logic [HILO_W-1:0]   lo
);

   generate
      if (LATENCY < 2 || LATENCY > LATENCY_MAX) begin : g_bad_latency
         $error("hilo_unit: LATENCY must be in 2..16");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PROD_W-1:0]   pend_q, pend_d;
   logic [HILO_W-1:0]   hi_q, hi_d;
   logic [HILO_W-1:0]   lo_q, lo_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         IDLE: begin
            // Moves write here; a same-cycle start will later overwrite them at commit.
            if (mthi) hi_d = wr_data;
            if (mtlo) lo_d = wr_data;
            if (start) begin
               pend_d  = prod;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (start) begin
               // Restart: the in-flight product is dropped without committing.
               pend_d = prod;
               cnt_d  = CNT_LOAD;
            end else if (cnt_q == CNT_W'(1)) begin
               hi_d    = pend_q[PROD_W-1:HILO_W];
               lo_d    = pend_q[HILO_W-1:0];
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == BUSY);
      stall = busy & (mfhi | mflo | mthi | mtlo);
      if (mfhi)      rd_data = hi_q;
      else if (mflo) rd_data = lo_q;
      else           rd_data = '0;
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: commits are scoreboarded (value and cycle) by a
// monitor that fires whenever busy falls; the initial block drives the steps.
module tb_hilo_unit;

   localparam int L = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] prod;
   logic        mfhi, mflo, mthi, mtlo;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        busy, stall;
   logic [31:0] hi, lo;

   hilo_unit #(.LATENCY(L)) dut (
      .clk(clk), .reset(reset), .start(start), .prod(prod),
      .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
      .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .stall(stall),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] val;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   ign_fall = 0;
   logic prev_busy = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Commit monitor: every busy->0 transition must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && prev_busy && !busy) begin
         if (ign_fall) begin
            ign_fall = 0;
         end else if (sb.size() == 0) begin
            chk("unexpected_commit", {hi, lo}, 64'hx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("commit_value", {hi, lo}, e.val);
            chk("commit_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      prev_busy = busy;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_start(input logic [63:0] p);
      exp_t e;
      start = 1'b1;
      prod  = p;
      e.val = p;
      e.cyc = cyc + L;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin
         step();
         n++;
      end
      chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      logic [63:0] a, b, c, d, f1, f2, p2, keep;
      a  = 64'hAAAA_0000_AAAA_0001;
      b  = 64'hBBBB_1111_BBBB_2222;
      c  = 64'hCCCC_3333_CCCC_4444;
      d  = 64'h0D0D_0D0D_D0D0_D0D0;
      f1 = 64'h1111_2222_3333_4444;
      f2 = 64'h5555_6666_7777_8888;
      p2 = 64'h0BAD_F00D_CAFE_0042;

      reset = 1'b1; start = 1'b0; prod = '0;
      mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
      step(); step();
      reset = 1'b0;

      // Reset state, reads return zero
      mfhi = 1'b1; #1;
      chk("rst_rd_hi", 64'(rd_data), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      mfhi = 1'b0; mflo = 1'b1; #1;
      chk("rst_rd_lo", 64'(rd_data), 64'd0);
      mflo = 1'b0;
      step();

      // Basic multiply: busy for L-1 cycles then commit
      push_start(64'h0000_0001_FFFF_FFFE);
      step();
      start = 1'b0;
      for (int i = 0; i < L - 1; i++) begin
         chk("basic_busy", {63'd0, busy}, 64'd1);
         step();
      end
      chk("basic_idle", {63'd0, busy}, 64'd0);
      chk("basic_hi", 64'(hi), 64'h1);
      chk("basic_lo", 64'(lo), 64'hFFFF_FFFE);
      mflo = 1'b1; #1;
      chk("mflo_rd", 64'(rd_data), 64'hFFFF_FFFE);
      mfhi = 1'b1; #1;
      chk("mfhi_prio", 64'(rd_data), 64'h1);
      mfhi = 1'b0; mflo = 1'b0;
      step();

      // mthi held across a busy window: stalls, then writes after commit
      push_start(p2);
      step();
      start = 1'b0;
      mthi = 1'b1; wr_data = 32'hDEAD_BEEF; #1;
      begin
         int n = 0;
         while (busy && n < 10) begin
            chk("mthi_stall", {63'd0, stall}, 64'd1);
            chk("mthi_hi_held", 64'(hi), 64'h1);
            step();
            n++;
         end
      end
      chk("mthi_unstall", {63'd0, stall}, 64'd0);
      step();
      mthi = 1'b0;
      chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
      chk("mthi_lo", 64'(lo), {32'd0, p2[31:0]});

      // Restart: A is dropped, only B commits (L cycles after B's start)
      keep = {hi, lo};
      start = 1'b1; prod = a;
      step();
      start = 1'b0;
      step();
      void'(sb.size());
      push_start(b);
      step();
      start = 1'b0;
      step();
      chk("restart_no_a", {hi, lo}, keep);
      wait_idle(10);
      chk("restart_b", {hi, lo}, b);

      // Reset in the second busy cycle discards the product
      step();
      start = 1'b1; prod = c;
      step();
      start = 1'b0;
      step();
      reset = 1'b1;
      ign_fall = 1;
      step();
      reset = 1'b0;
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      step(); step();
      chk("rst_no_commit", {hi, lo}, 64'd0);
      chk("rst_no_busy", {63'd0, busy}, 64'd0);
      ign_fall = 0;

      // Move-to plus start in the same IDLE cycle
      mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h1234_5678;
      push_start(d);
      step();
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      chk("mt_start_hilo", {hi, lo}, {2{32'h1234_5678}});
      chk("mt_start_busy", {63'd0, busy}, 64'd1);
      wait_idle(10);
      chk("mt_start_commit", {hi, lo}, d);

      // Back-to-back: start accepted in the cycle busy falls
      push_start(f1);
      step();
      start = 1'b0;
      wait_idle(10);
      push_start(f2);
      step();
      start = 1'b0;
      chk("b2b_busy", {63'd0, busy}, 64'd1);
      wait_idle(10);
      step();
      chk("b2b_final", {hi, lo}, f2);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #20000;
      n_fail++;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
